// File: rtl/hex_display_pkg.sv
// Shared constants for the DE1-SoC seven-segment display responder:
// register offsets, CTRL field layout and the active-low segment table.
package hex_display_pkg;

    localparam logic [1:0] REG_VALUE = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_RAW0  = 2'd2;
    localparam logic [1:0] REG_RAW1  = 2'd3;

    localparam int unsigned CTRL_EN_LSB    = 0;
    localparam int unsigned CTRL_BLINK_LSB = 8;
    localparam int unsigned CTRL_RAW_BIT   = 16;
    localparam int unsigned NUM_DIGITS     = 6;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index = nibble value; bit 6 = g, bit 0 = a, active-low.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic       raw;
        logic [5:0] blink;
        logic [5:0] en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{raw: 1'b0, blink: 6'h00, en: 6'h3F};

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_LSB +: 6]    = c.en;
        w[CTRL_BLINK_LSB +: 6] = c.blink;
        w[CTRL_RAW_BIT]        = c.raw;
        return w;
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.en    = w[CTRL_EN_LSB +: 6];
        c.blink = w[CTRL_BLINK_LSB +: 6];
        c.raw   = w[CTRL_RAW_BIT];
        return c;
    endfunction

endpackage

// File: rtl/hex_display_slave_if.sv
// Avalon-MM slave bus bundle for the seven-segment display responder.
interface hex_display_slave_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_slave.sv
// Avalon-MM responder driving six active-low seven-segment displays with
// per-digit enable, blink and raw-segment override; outputs are registered.
module hex_display_slave
    import hex_display_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    hex_display_slave_if.slave avs,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5
);
    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [23:0]      value_q;
    ctrl_t            ctrl_q;
    logic [27:0]      raw0_q;
    logic [13:0]      raw1_q;
    logic [31:0]      readdata_q;
    logic [31:0]      rd_word;
    logic [CNT_W-1:0] cnt_q;
    logic             hidden_q;
    logic             wr_en;
    logic             rd_en;
    logic [41:0]      raw_all;
    logic [6:0]       dec_seg [NUM_DIGITS];
    logic [6:0]       sel_seg [NUM_DIGITS];
    logic [6:0]       hex_q   [NUM_DIGITS];

    assign wr_en = avs.chipselect & avs.write;
    assign rd_en = avs.chipselect & avs.read;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            value_q <= '0;
            ctrl_q  <= CTRL_RESET;
            raw0_q  <= '0;
            raw1_q  <= '0;
        end else if (wr_en) begin
            unique case (avs.address)
                REG_VALUE: value_q <= avs.writedata[23:0];
                REG_CTRL:  ctrl_q  <= word_to_ctrl(avs.writedata);
                REG_RAW0:  raw0_q  <= avs.writedata[27:0];
                REG_RAW1:  raw1_q  <= avs.writedata[13:0];
            endcase
        end
    end

    // Mux reads the registers before this cycle's write lands.
    always_comb begin
        rd_word = '0;
        unique case (avs.address)
            REG_VALUE: rd_word = {8'h00, value_q};
            REG_CTRL:  rd_word = ctrl_to_word(ctrl_q);
            REG_RAW0:  rd_word = {4'h0, raw0_q};
            REG_RAW1:  rd_word = {18'h0, raw1_q};
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_word;
        end
    end

    assign avs.readdata = readdata_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q    <= '0;
            hidden_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            hidden_q <= ~hidden_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign raw_all = {raw1_q, raw0_q};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        hex_to_seg7 u_dec (
            .nibble (value_q[4*i +: 4]),
            .seg    (dec_seg[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_seg[i] = dec_seg[i];
            if (!ctrl_q.en[i]) begin
                sel_seg[i] = SEG_OFF;
            end else if (ctrl_q.blink[i] && hidden_q) begin
                sel_seg[i] = SEG_OFF;
            end else if (ctrl_q.raw) begin
                sel_seg[i] = raw_all[7*i +: 7];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_OFF;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= sel_seg[i];
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule
